norm_stream_compactor: RTL and testbench



---
 rtl/vdpu_pkg.sv | 25 ++
 rtl/multi_push_fifo.sv | 80 ++++++++
 rtl/norm_stream_compactor.sv | 170 +++++++++++++++++
 tb/tb_norm_stream_compactor.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdpu_pkg.sv
// Shared types and defaults for the norm compaction path.
// Contents:
//    DEFAULT_* constants : default lane count, ID/norm widths, FIFO depth
//    norm_entry_t        : one compacted stream entry {id, norm}
//    compactor_state_t   : control states of norm_stream_compactor
package vdpu_pkg;

   localparam int DEFAULT_LANES      = 8;
   localparam int DEFAULT_ID_WIDTH   = 32;
   localparam int DEFAULT_NORM_WIDTH = 32;
   localparam int DEFAULT_FIFO_DEPTH = 32;

   typedef struct packed {
      logic [DEFAULT_ID_WIDTH-1:0]   id;
      logic [DEFAULT_NORM_WIDTH-1:0] norm;
   } norm_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } compactor_state_t;

endpackage

// File: rtl/multi_push_fifo.sv
// Multi-push, single-pop FIFO with a show-ahead head.
// Up to LANES entries are written per cycle; set bits of push_mask are
// packed into consecutive slots in ascending lane order (prefix-sum indexing).
// The caller guarantees the number of set bits never exceeds free_count.
// Ports:
//    clk, rst    : clock, synchronous active-high reset (empties the FIFO)
//    push_mask   : per-lane write enable
//    push_data   : per-lane write data
//    pop         : remove the head entry (ignored when empty)
//    head        : current head entry, valid while !empty
//    empty       : no entries stored
//    occupancy   : entries stored (one extra bit separates full from empty)
//    free_count  : DEPTH - occupancy
module multi_push_fifo
   import vdpu_pkg::*;
#(
   parameter int LANES  = DEFAULT_LANES,
   parameter int DATA_W = DEFAULT_ID_WIDTH + DEFAULT_NORM_WIDTH,
   parameter int DEPTH  = DEFAULT_FIFO_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [LANES-1:0]  push_mask,
   input  logic [DATA_W-1:0] push_data [LANES],
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              empty,
   output logic [CNT_W-1:0]  occupancy,
   output logic [CNT_W-1:0]  free_count
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  slot [LANES];
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  push_count;
   logic              do_pop;

   // Each pushing lane lands at wr_ptr plus the number of pushing lanes
   // below it; pointer arithmetic wraps naturally at DEPTH.
   always_comb begin
      push_count = '0;
      for (int i = 0; i < LANES; i++) begin
         slot[i]    = wr_ptr + push_count[PTR_W-1:0];
         push_count = push_count + CNT_W'(push_mask[i]);
      end
   end

   assign do_pop     = pop && (count != '0);
   assign empty      = (count == '0);
   assign occupancy  = count;
   assign free_count = CNT_W'(DEPTH) - count;
   assign head       = mem[rd_ptr];

   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (push_mask[i]) begin
            mem[slot[i]] <= push_data[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + push_count[PTR_W-1:0];
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + push_count - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/norm_stream_compactor.sv
// Compacts sparsely-valid 8-lane inverse-norm beats into an in-order stream
// of {vector_id, inv_norm} entries drained one per cycle over valid/ready.
// IDs count up from base_id in lane order; a beat that does not fit is
// dropped whole but still advances the ID counter.
// Optional build macro NORM_COMPACT_ZERO_FILTER_EN: lanes carrying a zero
// norm are not enqueued but still consume an ID.
// Ports:
//    clk, rst     : clock, synchronous active-high reset
//    start        : pulse in idle: load base_id, clear counters/flags, run
//    finish       : pulse in run: no more beats; drain, then pulse done
//    base_id      : ID of the first entry after start
//    in_valid     : per-lane valid mask
//    in_norm      : per-lane inverse norms, lane i at [i*NORM_WIDTH +: NORM_WIDTH]
//    out_valid    : out_id/out_norm carry the head entry
//    out_ready    : consumer accepts when out_valid & out_ready
//    out_id       : head entry vector ID
//    out_norm     : head entry inverse norm
//    done         : one-cycle pulse when the drain completes
//    overflow     : sticky, a beat was dropped since start
//    entry_count  : entries handed off since start
module norm_stream_compactor
   import vdpu_pkg::*;
#(
   parameter int LANES      = DEFAULT_LANES,
   parameter int ID_WIDTH   = DEFAULT_ID_WIDTH,
   parameter int NORM_WIDTH = DEFAULT_NORM_WIDTH,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        finish,
   input  logic [ID_WIDTH-1:0]         base_id,
   input  logic [LANES-1:0]            in_valid,
   input  logic [LANES*NORM_WIDTH-1:0] in_norm,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [ID_WIDTH-1:0]         out_id,
   output logic [NORM_WIDTH-1:0]       out_norm,
   output logic                        done,
   output logic                        overflow,
   output logic [ID_WIDTH-1:0]         entry_count
);

   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int DATA_W = ID_WIDTH + NORM_WIDTH;

   compactor_state_t      state;
   compactor_state_t      state_next;
   logic [ID_WIDTH-1:0]   next_id;
   logic [ID_WIDTH-1:0]   beat_ids;
   logic [LANES-1:0]      keep_mask;
   logic [LANES-1:0]      push_mask;
   logic [DATA_W-1:0]     lane_data [LANES];
   logic [CNT_W-1:0]      keep_count;
   logic [CNT_W-1:0]      free_count;
   logic [CNT_W-1:0]      occupancy;
   logic [DATA_W-1:0]     head_data;
   logic                  fifo_empty;
   logic                  beat_fits;
   logic                  running;
   logic                  pop;

   // Lanes that actually enter the FIFO.
   always_comb begin
      keep_mask = in_valid;
`ifdef NORM_COMPACT_ZERO_FILTER_EN
      for (int i = 0; i < LANES; i++) begin
         if (in_norm[i*NORM_WIDTH +: NORM_WIDTH] == '0) begin
            keep_mask[i] = 1'b0;
         end
      end
`endif
   end

   // The ID of a lane is its rank among all valid lanes, so filtered lanes
   // still leave a gap in the ID sequence.
   always_comb begin
      beat_ids   = '0;
      keep_count = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_data[i] = {next_id + beat_ids, in_norm[i*NORM_WIDTH +: NORM_WIDTH]};
         beat_ids     = beat_ids + ID_WIDTH'(in_valid[i]);
         keep_count   = keep_count + CNT_W'(keep_mask[i]);
      end
   end

   // Free space is judged on occupancy before any same-cycle pop.
   assign running   = (state == ST_RUN);
   assign beat_fits = (keep_count <= free_count);
   assign push_mask = (running && beat_fits) ? keep_mask : '0;
   assign pop       = out_valid && out_ready;

   multi_push_fifo #(
      .LANES  (LANES),
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_mask  (push_mask),
      .push_data  (lane_data),
      .pop        (pop),
      .head       (head_data),
      .empty      (fifo_empty),
      .occupancy  (occupancy),
      .free_count (free_count)
   );

   assign out_valid = !fifo_empty;
   assign out_id    = fifo_empty ? '0 : head_data[DATA_W-1 -: ID_WIDTH];
   assign out_norm  = fifo_empty ? '0 : head_data[NORM_WIDTH-1:0];

   // Drain ends as soon as the last entry leaves, so done follows the final
   // handshake by exactly one cycle.
   always_comb begin
      state_next = state;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (finish) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty || (occupancy == CNT_W'(1) && pop)) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State register, ID counter, sticky overflow and hand-off counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         next_id     <= '0;
         overflow    <= 1'b0;
         entry_count <= '0;
      end else begin
         state <= state_next;
         if (state == ST_IDLE && start) begin
            next_id     <= base_id;
            overflow    <= 1'b0;
            entry_count <= '0;
         end else begin
            if (running) begin
               next_id <= next_id + beat_ids;
               if (!beat_fits) begin
                  overflow <= 1'b1;
               end
            end
            if (pop) begin
               entry_count <= entry_count + ID_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_norm_stream_compactor.sv
// Self-checking bench for norm_stream_compactor: a queue-based model of the
// entry stream is compared against the DUT every cycle, and directed
// scenarios pin specific IDs, norms and flag values.
// Honours NORM_COMPACT_ZERO_FILTER_EN the same way as the design.
module tb_norm_stream_compactor;
   import vdpu_pkg::*;

   localparam int PH_IDLE  = 0;
   localparam int PH_RUN   = 1;
   localparam int PH_DRAIN = 2;
   localparam int PH_DONE  = 3;
`ifdef NORM_COMPACT_ZERO_FILTER_EN
   localparam bit FILTER = 1'b1;
`else
   localparam bit FILTER = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         finish;
   logic [31:0]  base_id;
   logic [7:0]   in_valid;
   logic [255:0] in_norm;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_id;
   logic [31:0]  out_norm;
   logic         done;
   logic         overflow;
   logic [31:0]  entry_count;

   int n_checks = 0;
   int n_fail   = 0;
   int cycle    = 0;
   int last_pop_cycle = 0;
   int done_cycle     = 0;
   int done_count     = 0;

   norm_entry_t exp_q[$];
   norm_entry_t got_q[$];
   int          m_phase = PH_IDLE;
   logic [31:0] m_next_id = '0;
   logic [31:0] m_count = '0;
   logic        m_overflow = 1'b0;
   bit          model_live = 1'b0;

   norm_stream_compactor dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .finish      (finish),
      .base_id     (base_id),
      .in_valid    (in_valid),
      .in_norm     (in_norm),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_id      (out_id),
      .out_norm    (out_norm),
      .done        (done),
      .overflow    (overflow),
      .entry_count (entry_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cycle);
      end
   endtask

   function automatic logic [255:0] mkNorms(input int first);
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = 32'(first + i);
      return v;
   endfunction

   // Advance the model by the clock edge that follows this sample point.
   task automatic advanceModel();
      int          size_before;
      int          rank;
      norm_entry_t e;
      norm_entry_t kept[$];
      if (rst) begin
         exp_q.delete();
         m_phase    = PH_IDLE;
         m_next_id  = '0;
         m_count    = '0;
         m_overflow = 1'b0;
         model_live = 1'b1;
         return;
      end
      if (!model_live) return;
      size_before = exp_q.size();
      if (out_ready && size_before > 0) begin
         void'(exp_q.pop_front());
         m_count++;
      end
      case (m_phase)
         PH_IDLE: if (start) begin
            m_phase    = PH_RUN;
            m_next_id  = base_id;
            m_overflow = 1'b0;
            m_count    = '0;
         end
         PH_RUN: begin
            rank = 0;
            for (int i = 0; i < 8; i++) begin
               if (in_valid[i]) begin
                  e.id   = m_next_id + 32'(rank);
                  e.norm = in_norm[i*32 +: 32];
                  rank++;
                  if (!(FILTER && e.norm == 32'd0)) kept.push_back(e);
               end
            end
            if (kept.size() <= 32 - size_before) begin
               foreach (kept[j]) exp_q.push_back(kept[j]);
            end else begin
               m_overflow = 1'b1;
            end
            m_next_id = m_next_id + 32'(rank);
            if (finish) m_phase = PH_DRAIN;
         end
         PH_DRAIN: if (exp_q.size() == 0) m_phase = PH_DONE;
         default:  m_phase = PH_IDLE;
      endcase
   endtask

   // Per-cycle comparison against the model, sampled mid-cycle.
   initial begin
      norm_entry_t g;
      forever begin
         @(negedge clk);
         cycle++;
         if (model_live && !rst) begin
            checkOutput("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
               checkOutput("out_id", out_id, exp_q[0].id);
               checkOutput("out_norm", out_norm, exp_q[0].norm);
            end
            checkOutput("done", done, m_phase == PH_DONE);
            checkOutput("overflow", overflow, m_overflow);
            checkOutput("entry_count", entry_count, m_count);
         end
         if (!rst && out_valid === 1'b1 && out_ready) begin
            g.id   = out_id;
            g.norm = out_norm;
            got_q.push_back(g);
            last_pop_cycle = cycle;
         end
         if (!rst && done === 1'b1) begin
            done_count++;
            done_cycle = cycle;
         end
         advanceModel();
      end
   end

   // One cycle of inputs, then return to idle inputs.
   task automatic applyStimulus(input bit st, input bit fin, input logic [31:0] base,
                                input logic [7:0] valid, input logic [255:0] norms);
      start    = st;
      finish   = fin;
      base_id  = base;
      in_valid = valid;
      in_norm  = norms;
      @(posedge clk);
      #1;
      start    = 1'b0;
      finish   = 1'b0;
      in_valid = '0;
   endtask

   task automatic waitDone(input int max_cycles);
      int n = 0;
      while (done !== 1'b1 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      checkOutput("done_seen", done, 1'b1);
      @(posedge clk);
      #1;
   endtask

   task automatic waitEmpty(input int max_cycles);
      int n = 0;
      while (out_valid !== 1'b0 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drained", out_valid, 1'b0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [255:0] nv;
      int           dc0;
      rst = 1'b1; start = 1'b0; finish = 1'b0; base_id = '0;
      in_valid = '0; in_norm = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst_out_valid", out_valid, 1'b0);
      checkOutput("rst_out_id", out_id, 32'd0);
      checkOutput("rst_out_norm", out_norm, 32'd0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_overflow", overflow, 1'b0);
      checkOutput("rst_entry_count", entry_count, 32'd0);

      $display("[TB] full beat from base 100");
      got_q.delete();
      applyStimulus(1, 0, 32'd100, 8'h00, '0);
      applyStimulus(0, 0, 32'd0, 8'hFF, mkNorms(1));
      applyStimulus(0, 1, 32'd0, 8'h00, '0);
      waitDone(40);
      checkOutput("t1_count", got_q.size(), 8);
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         checkOutput("t1_id", got_q[i].id, 32'(100 + i));
         checkOutput("t1_norm", got_q[i].norm, 32'(1 + i));
      end
      checkOutput("t1_entry_count", entry_count, 32'd8);

      $display("[TB] sparse masks");
      got_q.delete();
      applyStimulus(1, 0, 32'd0, 8'h00, '0);
      applyStimulus(0, 0, 32'd0, 8'b0000_0011, mkNorms(16));
      applyStimulus(0, 0, 32'd0, 8'b1000_0100, mkNorms(16));
      applyStimulus(0, 1, 32'd0, 8'h00, '0);
      waitDone(40);
      checkOutput("t2_count", got_q.size(), 4);
      if (got_q.size() == 4) begin
         checkOutput("t2_id3", got_q[3].id, 32'd3);
         checkOutput("t2_norm0", got_q[0].norm, 32'h10);
         checkOutput("t2_norm2", got_q[2].norm, 32'h12);
         checkOutput("t2_norm3", got_q[3].norm, 32'h17);
      end

      $display("[TB] overflow with stalled consumer");
      got_q.delete();
      out_ready = 1'b0;
      applyStimulus(1, 0, 32'd0, 8'h00, '0);
      for (int b = 0; b < 5; b++) applyStimulus(0, 0, 32'd0, 8'hFF, mkNorms(8 * b));
      checkOutput("t3_overflow", overflow, 1'b1);
      out_ready = 1'b1;
      waitEmpty(80);
      checkOutput("t3_drained_count", got_q.size(), 32);
      if (got_q.size() == 32) checkOutput("t3_last_id", got_q[31].id, 32'd31);
      applyStimulus(0, 0, 32'd0, 8'h01, mkNorms(32'hAA));
      applyStimulus(0, 1, 32'd0, 8'h00, '0);
      waitDone(40);
      if (got_q.size() == 33) checkOutput("t3_next_id", got_q[32].id, 32'd40);
      else checkOutput("t3_total", got_q.size(), 33);
      checkOutput("t3_overflow_sticky", overflow, 1'b1);

      $display("[TB] finish with entries queued");
      got_q.delete();
      out_ready = 1'b0;
      applyStimulus(1, 0, 32'd0, 8'h00, '0);
      applyStimulus(0, 0, 32'd0, 8'h07, mkNorms(50));
      applyStimulus(0, 1, 32'd0, 8'h00, '0);
      applyStimulus(1, 0, 32'd77, 8'h00, '0);
      dc0 = done_count;
      out_ready = 1'b1;
      waitDone(40);
      repeat (3) applyStimulus(0, 0, 32'd0, 8'hFF, mkNorms(1));
      checkOutput("t4_outputs", got_q.size(), 3);
      checkOutput("t4_done_gap", done_cycle - last_pop_cycle, 1);
      checkOutput("t4_done_pulses", done_count - dc0, 1);
      checkOutput("t4_entry_count", entry_count, 32'd3);
      checkOutput("t4_idle_empty", out_valid, 1'b0);

      $display("[TB] finish with a beat");
      got_q.delete();
      applyStimulus(1, 0, 32'd0, 8'h00, '0);
      applyStimulus(0, 1, 32'd0, 8'h0F, mkNorms(5));
      waitDone(40);
      checkOutput("t5_count", got_q.size(), 4);
      if (got_q.size() == 4) checkOutput("t5_last_id", got_q[3].id, 32'd3);

      $display("[TB] zero-norm lane");
      got_q.delete();
      nv = mkNorms(9);
      nv[63:32] = 32'd0;
      applyStimulus(1, 0, 32'd0, 8'h00, '0);
      applyStimulus(0, 0, 32'd0, 8'h0F, nv);
      applyStimulus(0, 1, 32'd0, 8'h00, '0);
      waitDone(40);
`ifdef NORM_COMPACT_ZERO_FILTER_EN
      checkOutput("t6_count", got_q.size(), 3);
      if (got_q.size() == 3) begin
         checkOutput("t6_id1", got_q[1].id, 32'd2);
         checkOutput("t6_id2", got_q[2].id, 32'd3);
      end
`else
      checkOutput("t6_count", got_q.size(), 4);
      if (got_q.size() == 4) begin
         checkOutput("t6_id1", got_q[1].id, 32'd1);
         checkOutput("t6_norm1", got_q[1].norm, 32'd0);
      end
`endif

      $display("[TB] reset mid-run");
      out_ready = 1'b0;
      applyStimulus(1, 0, 32'd0, 8'h00, '0);
      applyStimulus(0, 0, 32'd0, 8'hFF, mkNorms(3));
      dc0 = done_count;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      checkOutput("t7_out_valid", out_valid, 1'b0);
      checkOutput("t7_entry_count", entry_count, 32'd0);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("t7_no_done", done_count - dc0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
